// File: rtl/neon_axil_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS slots of DATA_WIDTH bits, byte-strobe writes,
// per-slot write pulses, read-only status slots and SLVERR on out-of-range addresses.
module neon_axil_regbank #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WHaveA, WHaveD, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      cm_idx, ar_idx;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;
  logic                  cm_in_range, ar_in_range;

  // Byte-offset bits of both addresses carry no information for word-sized slots.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign ar_idx = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  // Commit operands: take whichever half arrived earlier from its holding register.
  always_comb begin
    cm_idx      = (wstate_q == WHaveA) ? aw_idx_q : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    cm_data     = (wstate_q == WHaveD) ? w_data_q : WDATA;
    cm_strb     = (wstate_q == WHaveD) ? w_strb_q : WSTRB;
    cm_in_range = 32'(cm_idx) < NUM_REGS;
    ar_in_range = 32'(ar_idx) < NUM_REGS;
  end

  // Write FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wstate_q <= WIdle;
    else        wstate_q <= wstate_d;
  end

  // Write FSM next state; commit marks the edge of the final AW/W handshake.
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    unique case (wstate_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          wstate_d = WResp;
        end else if (aw_hs) begin
          wstate_d = WHaveA;
        end else if (w_hs) begin
          wstate_d = WHaveD;
        end
      end
      WHaveA: if (w_hs) begin
        commit   = 1'b1;
        wstate_d = WResp;
      end
      WHaveD: if (aw_hs) begin
        commit   = 1'b1;
        wstate_d = WResp;
      end
      WResp:   if (BREADY) wstate_d = WIdle;
      default: wstate_d = WIdle;
    endcase
  end

  // Write channel outputs decoded from the state.
  always_comb begin
    AWREADY = (wstate_q == WIdle) || (wstate_q == WHaveD);
    WREADY  = (wstate_q == WIdle) || (wstate_q == WHaveA);
    BVALID  = (wstate_q == WResp);
    BRESP   = bresp_q;
  end

  // Hold the early half of a split write until its partner arrives.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
    end
  end

  // Register file update, write pulses and write response on commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      wr_pulse_q <= '0;
      bresp_q    <= RespOkay;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_q[i] <= 1'b0;
        if (commit && cm_in_range && cm_idx == IDX_W'(i) && !RO_MASK[i]) begin
          wr_pulse_q[i] <= 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (cm_strb[k]) regs_q[i][k*8 +: 8] <= cm_data[k*8 +: 8];
          end
        end
      end
      if (commit) bresp_q <= cm_in_range ? RespOkay : RespSlvErr;
    end
  end

  assign wr_pulse = wr_pulse_q;

  // Flatten RW slots onto reg_out; RO slots read as zero.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rstate_q <= RIdle;
    else        rstate_q <= rstate_d;
  end

  // Read FSM next state.
  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      RIdle:   if (ar_hs) rstate_d = RData;
      RData:   if (RREADY) rstate_d = RIdle;
      default: rstate_d = RIdle;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    ARREADY = (rstate_q == RIdle);
    RVALID  = (rstate_q == RData);
    RDATA   = rdata_q;
    RRESP   = rresp_q;
  end

  // Read data mux: RW slots from the register file, RO slots from status_in.
  always_comb begin
    rdata_d = '0;
    rresp_d = ar_in_range ? RespOkay : RespSlvErr;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_in_range && ar_idx == IDX_W'(i)) begin
        rdata_d = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  // Capture read data at the AR handshake; held stable until the R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else if (ar_hs) begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

endmodule
